bank_write_arbiter: RTL and testbench
=====================================

Name: bank_write_arbiter

Overview:
- Shares the BANK_COUNT single-write-port activation buffer banks between two requesters: the local output path (own-tile results) and the neighbor input path (halo values, already bank-steered).
- Per bank, arbitrates round-robin when both requesters collide, and back-pressures the loser with a per-bank ready.
- Also sequences each tile: latches and drives the bitwidth configuration, drains in-flight writes at tile end, and pulses done.
- Sits between the bank-steering stages and the buffer bank write ports.

Parameters:
BANK_COUNT, 32, number of buffer banks; power of two.
TILE_SIZE, 128, tile dimension; row and column width is clog2(TILE_SIZE).

Ports:
clk  in  1  clock; all state on rising edge.
reset_n  in  1  asynchronous active-low reset.
start  in  1  begin tile; sampled in IDLE only.
bitwidth_in  in  2  bitwidth for the tile; latched on accepted start.
tile_end  in  1  no further new requests this tile.
neighbor_leftover  in  1  neighbor path still holds unissued inputs.
local_valid  in  BANK_COUNT  per-bank local write request.
local_row, local_column  in  [BANK_COUNT] x clog2(TILE_SIZE)  local write address.
local_data  in  [BANK_COUNT] x 8  local write data.
neighbor_valid  in  BANK_COUNT  per-bank neighbor write request.
neighbor_row, neighbor_column  in  [BANK_COUNT] x clog2(TILE_SIZE)  neighbor write address.
neighbor_data  in  [BANK_COUNT] x 8  neighbor write data.
local_ready  out  BANK_COUNT  combinational; local request accepted this cycle.
neighbor_ready  out  BANK_COUNT  combinational; neighbor request accepted this cycle.
buffer_row_write, buffer_column_write  out  [BANK_COUNT] x clog2(TILE_SIZE)  registered bank address.
buffer_data_write  out  [BANK_COUNT] x 8  registered bank data.
buffer_write_enable  out  BANK_COUNT  registered bank write strobe.
cfg_bitwidth  out  2  latched bitwidth, stable for the whole tile.
busy  out  1  high in ACTIVE or DRAIN.
done  out  1  one-cycle pulse at tile completion.
conflict_count  out  16  saturating count of per-bank collisions this tile.

Behaviour:
- Reset, asynchronous: state=IDLE; all buffer_* outputs 0; cfg_bitwidth=0; done=0; conflict_count=0; all rr pointers=LOCAL. Reset mid-tile aborts the tile; nothing is flushed.
- FSM states:
  - IDLE: start=1 -> ACTIVE; latch bitwidth_in; clear conflict_count. tile_end in IDLE is ignored.
  - ACTIVE: tile_end=1 -> DRAIN. A start in ACTIVE is ignored.
  - DRAIN: stays until a cycle with no local_valid bit, no neighbor_valid bit, and neighbor_leftover=0. That cycle -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE. A start in DONE is ignored.
- Ready gating: in IDLE and DONE, all ready=0 and no writes are issued. Requests are accepted only in ACTIVE and DRAIN.
- Per-bank arbitration, for bank b in ACTIVE or DRAIN:
  - Only one requester valid: that requester gets ready=1.
  - Both valid: the side named by rr[b] wins. rr[b] flips to the other side. conflict_count increments, saturating at 0xFFFF.
  - No conflict: rr[b] is unchanged.
  - Worst-case wait for a losing requester is 1 cycle.
  - Ready for a non-valid requester is don't-care; the bench checks ready only when valid=1.
- Handshake: valid/ready per bank per side. A request must hold stable while valid=1 and ready=0.
- Latency: a request accepted in cycle t appears on buffer_* with buffer_write_enable[b]=1 in cycle t+1. If no request is accepted for bank b, write_enable[b]=0 and address/data are held.
- A DRAIN exit in cycle t therefore has its last write visible at t and done at t+1. The last write never coincides with done.
- Banks are independent. All 32 banks may write in the same cycle.
- Width rules: addresses and data pass through unmodified; no bank remapping is done here.

Decomposition:
- Shared package bfcnn_buf_pkg:
  - typedefs row_t and col_t (clog2(TILE_SIZE) bits) and data_t (8 bits).
  - enum arb_state_e {IDLE, ACTIVE, DRAIN, DONE}.
  - constants SRC_LOCAL=0 and SRC_NEIGHBOR=1.
  - CONFLICT_MAX=16'hFFFF.
- One sub-module bank_rr_arbiter_2to1:
  - holds the rr bit and output register for one bank.
  - outputs the two readies and a conflict flag.
  - instantiated BANK_COUNT times by generate.
- The top holds the FSM, the config latch, and the conflict adder, which sums the per-bank flags and saturates.

Test Plan:
- Reset then start with bitwidth_in=2: cfg_bitwidth=2, busy=1. Local-only request on bank 5, row=3 col=7 data=0xA5 -> next cycle write_enable[5]=1, row 3, col 7, data 0xA5; neighbor_ready irrelevant.
- Both sides valid on bank 0 for 4 cycles, different data each side: grants alternate L,N,L,N; outputs alternate the same way; conflict_count=4.
- All 32 banks valid on local and neighbor for 1 cycle: 32 local grants, 32 writes next cycle, conflict_count=32. The held neighbor requests are granted the following cycle.
- tile_end while neighbor_leftover=1 for 3 cycles, then 0 with no valids: stays in DRAIN 3 cycles; done pulses once, 1 cycle after the exit cycle; state returns to IDLE with busy=0.
- Valids asserted in IDLE and DONE, and start pulsed during ACTIVE: all ready=0 in IDLE/DONE, no write_enable, cfg_bitwidth unchanged.
- reset_n asserted mid-ACTIVE, between clock edges: immediately all write_enable=0, conflict_count=0, state=IDLE, cfg_bitwidth=0.
- Force 70000 conflicts: conflict_count saturates at 0xFFFF.

Source files
------------

// File: rtl/bfcnn_buf_pkg.sv
// Shared types and constants for the activation-buffer write path.
// Bank addresses are clog2(TILE_SIZE) bits wide; data is one byte per bank.
package bfcnn_buf_pkg;

   localparam int TILE_SIZE_DEF = 128;
   localparam int ADDR_W        = $clog2(TILE_SIZE_DEF);

   typedef logic [ADDR_W-1:0] row_t;
   typedef logic [ADDR_W-1:0] col_t;
   typedef logic [7:0]        data_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DRAIN  = 2'd2,
      DONE   = 2'd3
   } arb_state_e;

   localparam logic        SRC_LOCAL    = 1'b0;
   localparam logic        SRC_NEIGHBOR = 1'b1;
   localparam logic [15:0] CONFLICT_MAX = 16'hFFFF;

   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[16] ? CONFLICT_MAX : sum[15:0];
   endfunction

endpackage

// File: rtl/bank_rr_arbiter_2to1.sv
// Two-requester round-robin arbiter for one buffer bank, with the bank's
// registered write port. The rr bit only moves on an actual collision.
module bank_rr_arbiter_2to1
   import bfcnn_buf_pkg::*;
#(
   parameter int AW = ADDR_W
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          enable,
   input  logic          local_valid,
   input  logic [AW-1:0] local_row,
   input  logic [AW-1:0] local_column,
   input  data_t         local_data,
   input  logic          neighbor_valid,
   input  logic [AW-1:0] neighbor_row,
   input  logic [AW-1:0] neighbor_column,
   input  data_t         neighbor_data,
   output logic          local_ready,
   output logic          neighbor_ready,
   output logic          conflict,
   output logic [AW-1:0] row_write,
   output logic [AW-1:0] column_write,
   output data_t         data_write,
   output logic          write_enable
);

   logic          rr_q;
   logic          we_q;
   logic [AW-1:0] row_q;
   logic [AW-1:0] col_q;
   data_t         data_q;

   always_comb begin
      conflict       = enable & local_valid & neighbor_valid;
      local_ready    = enable & local_valid    & (~neighbor_valid | (rr_q == SRC_LOCAL));
      neighbor_ready = enable & neighbor_valid & (~local_valid    | (rr_q == SRC_NEIGHBOR));
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_q   <= SRC_LOCAL;
         we_q   <= 1'b0;
         row_q  <= '0;
         col_q  <= '0;
         data_q <= '0;
      end else begin
         if (conflict) rr_q <= ~rr_q;
         we_q <= local_ready | neighbor_ready;
         if (local_ready) begin
            row_q  <= local_row;
            col_q  <= local_column;
            data_q <= local_data;
         end else if (neighbor_ready) begin
            row_q  <= neighbor_row;
            col_q  <= neighbor_column;
            data_q <= neighbor_data;
         end
      end
   end

   assign write_enable = we_q;
   assign row_write    = row_q;
   assign column_write = col_q;
   assign data_write   = data_q;

endmodule

// File: rtl/bank_write_arbiter.sv
// Shares the single-write-port buffer banks between the local and neighbor
// paths, and sequences each tile (config latch, drain, done pulse).
module bank_write_arbiter
   import bfcnn_buf_pkg::*;
#(
   parameter  int BANK_COUNT = 32,
   parameter  int TILE_SIZE  = 128,
   localparam int AW         = $clog2(TILE_SIZE)
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           start,
   input  logic [1:0]                     bitwidth_in,
   input  logic                           tile_end,
   input  logic                           neighbor_leftover,
   input  logic [BANK_COUNT-1:0]          local_valid,
   input  logic [BANK_COUNT-1:0][AW-1:0]  local_row,
   input  logic [BANK_COUNT-1:0][AW-1:0]  local_column,
   input  logic [BANK_COUNT-1:0][7:0]     local_data,
   input  logic [BANK_COUNT-1:0]          neighbor_valid,
   input  logic [BANK_COUNT-1:0][AW-1:0]  neighbor_row,
   input  logic [BANK_COUNT-1:0][AW-1:0]  neighbor_column,
   input  logic [BANK_COUNT-1:0][7:0]     neighbor_data,
   output logic [BANK_COUNT-1:0]          local_ready,
   output logic [BANK_COUNT-1:0]          neighbor_ready,
   output logic [BANK_COUNT-1:0][AW-1:0]  buffer_row_write,
   output logic [BANK_COUNT-1:0][AW-1:0]  buffer_column_write,
   output logic [BANK_COUNT-1:0][7:0]     buffer_data_write,
   output logic [BANK_COUNT-1:0]          buffer_write_enable,
   output logic [1:0]                     cfg_bitwidth,
   output logic                           busy,
   output logic                           done,
   output logic [15:0]                    conflict_count
);

   arb_state_e            state_q;
   logic [1:0]            cfg_q;
   logic                  busy_q;
   logic                  done_q;
   logic [15:0]           conflict_q;
   logic [15:0]           conflict_sum;
   logic [15:0]           conflict_d;
   logic [BANK_COUNT-1:0] bank_conflict;
   logic                  arb_enable;
   logic                  drain_empty;

   assign arb_enable  = (state_q == ACTIVE) || (state_q == DRAIN);
   assign drain_empty = ~(|local_valid) & ~(|neighbor_valid) & ~neighbor_leftover;

   for (genvar b = 0; b < BANK_COUNT; b++) begin : g_bank
      bank_rr_arbiter_2to1 #(.AW(AW)) u_arb (
         .clk             (clk),
         .reset_n         (reset_n),
         .enable          (arb_enable),
         .local_valid     (local_valid[b]),
         .local_row       (local_row[b]),
         .local_column    (local_column[b]),
         .local_data      (local_data[b]),
         .neighbor_valid  (neighbor_valid[b]),
         .neighbor_row    (neighbor_row[b]),
         .neighbor_column (neighbor_column[b]),
         .neighbor_data   (neighbor_data[b]),
         .local_ready     (local_ready[b]),
         .neighbor_ready  (neighbor_ready[b]),
         .conflict        (bank_conflict[b]),
         .row_write       (buffer_row_write[b]),
         .column_write    (buffer_column_write[b]),
         .data_write      (buffer_data_write[b]),
         .write_enable    (buffer_write_enable[b])
      );
   end

   // NOTE: combinational blocks assign a default before any loop or branch,
   // so no path leaves a variable unassigned and no latch is inferred.
   always_comb begin
      conflict_sum = '0;
      for (int b = 0; b < BANK_COUNT; b++) begin
         conflict_sum = conflict_sum + 16'(bank_conflict[b]);
      end
      conflict_d = sat_add16(conflict_q, conflict_sum);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         cfg_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         conflict_q <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  state_q    <= ACTIVE;
                  busy_q     <= 1'b1;
                  cfg_q      <= bitwidth_in;
                  conflict_q <= '0;
               end
            end
            ACTIVE: begin
               conflict_q <= conflict_d;
               if (tile_end) state_q <= DRAIN;
            end
            DRAIN: begin
               conflict_q <= conflict_d;
               // Exit only once both paths are provably empty this cycle.
               if (drain_empty) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign cfg_bitwidth   = cfg_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign conflict_count = conflict_q;

endmodule

// File: tb/tb_bank_write_arbiter.sv
// Randomized scoreboard bench for bank_write_arbiter: a per-bank queue of
// expected writes is filled by the driver's model and drained by a monitor.
module tb_bank_write_arbiter;

   localparam int BC = 32;
   localparam int AW = 7;

   logic                  clk = 1'b0;
   logic                  reset_n;
   logic                  start;
   logic [1:0]            bitwidth_in;
   logic                  tile_end;
   logic                  neighbor_leftover;
   logic [BC-1:0]         local_valid;
   logic [BC-1:0][AW-1:0] local_row;
   logic [BC-1:0][AW-1:0] local_column;
   logic [BC-1:0][7:0]    local_data;
   logic [BC-1:0]         neighbor_valid;
   logic [BC-1:0][AW-1:0] neighbor_row;
   logic [BC-1:0][AW-1:0] neighbor_column;
   logic [BC-1:0][7:0]    neighbor_data;
   logic [BC-1:0]         local_ready;
   logic [BC-1:0]         neighbor_ready;
   logic [BC-1:0][AW-1:0] buffer_row_write;
   logic [BC-1:0][AW-1:0] buffer_column_write;
   logic [BC-1:0][7:0]    buffer_data_write;
   logic [BC-1:0]         buffer_write_enable;
   logic [1:0]            cfg_bitwidth;
   logic                  busy;
   logic                  done;
   logic [15:0]           conflict_count;

   bank_write_arbiter #(.BANK_COUNT(BC), .TILE_SIZE(128)) dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .start               (start),
      .bitwidth_in         (bitwidth_in),
      .tile_end            (tile_end),
      .neighbor_leftover   (neighbor_leftover),
      .local_valid         (local_valid),
      .local_row           (local_row),
      .local_column        (local_column),
      .local_data          (local_data),
      .neighbor_valid      (neighbor_valid),
      .neighbor_row        (neighbor_row),
      .neighbor_column     (neighbor_column),
      .neighbor_data       (neighbor_data),
      .local_ready         (local_ready),
      .neighbor_ready      (neighbor_ready),
      .buffer_row_write    (buffer_row_write),
      .buffer_column_write (buffer_column_write),
      .buffer_data_write   (buffer_data_write),
      .buffer_write_enable (buffer_write_enable),
      .cfg_bitwidth        (cfg_bitwidth),
      .busy                (busy),
      .done                (done),
      .conflict_count      (conflict_count)
   );

   always #5 clk = ~clk;

   typedef enum {M_IDLE, M_ACTIVE, M_DRAIN, M_DONE} mphase_e;

   typedef struct {
      int            cyc;
      logic [AW-1:0] row;
      logic [AW-1:0] col;
      logic [7:0]    data;
   } exp_t;

   exp_t          exp_q[BC][$];
   mphase_e       m_phase;
   logic [1:0]    m_cfg;
   int            m_conf;
   logic [BC-1:0] m_rr_nb;
   int            cyc = 0;
   int            n_tests = 0;
   int            n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every write the DUT presents must be the next one the model expects.
   always @(negedge clk) begin
      if (reset_n) begin
         for (int b = 0; b < BC; b++) begin
            if (exp_q[b].size() > 0 && exp_q[b][0].cyc == cyc) begin
               exp_t e;
               e = exp_q[b].pop_front();
               check($sformatf("we[%0d]", b), 32'(buffer_write_enable[b]), 32'd1);
               check($sformatf("row[%0d]", b), 32'(buffer_row_write[b]), 32'(e.row));
               check($sformatf("col[%0d]", b), 32'(buffer_column_write[b]), 32'(e.col));
               check($sformatf("data[%0d]", b), 32'(buffer_data_write[b]), 32'(e.data));
            end else begin
               check($sformatf("idle_we[%0d]", b), 32'(buffer_write_enable[b]), 32'd0);
            end
         end
      end
   end

   task automatic model_reset();
      m_phase = M_IDLE;
      m_cfg   = 2'd0;
      m_conf  = 0;
      m_rr_nb = '0;
      for (int b = 0; b < BC; b++) exp_q[b].delete();
   endtask

   task automatic clear_stim();
      start             = 1'b0;
      bitwidth_in       = 2'd0;
      tile_end          = 1'b0;
      neighbor_leftover = 1'b0;
      local_valid       = '0;
      neighbor_valid    = '0;
      local_row         = '0;
      local_column      = '0;
      local_data        = '0;
      neighbor_row      = '0;
      neighbor_column   = '0;
      neighbor_data     = '0;
   endtask

   task automatic rand_req(input int b, input bit nb);
      if (!nb) begin
         local_valid[b]  = 1'b1;
         local_row[b]    = AW'($urandom);
         local_column[b] = AW'($urandom);
         local_data[b]   = 8'($urandom);
      end else begin
         neighbor_valid[b]  = 1'b1;
         neighbor_row[b]    = AW'($urandom);
         neighbor_column[b] = AW'($urandom);
         neighbor_data[b]   = 8'($urandom);
      end
   endtask

   // One clock of stimulus: entered and left at posedge+1 with inputs applied.
   task automatic step();
      logic [BC-1:0] gl;
      logic [BC-1:0] gn;
      int            nc;
      bit            en;
      #1;
      check("busy", 32'(busy), 32'(m_phase == M_ACTIVE || m_phase == M_DRAIN));
      check("done", 32'(done), 32'(m_phase == M_DONE));
      check("cfg_bitwidth", 32'(cfg_bitwidth), 32'(m_cfg));
      check("conflict_count", 32'(conflict_count), 32'(m_conf));
      en = (m_phase == M_ACTIVE || m_phase == M_DRAIN);
      nc = 0;
      gl = '0;
      gn = '0;
      for (int b = 0; b < BC; b++) begin
         if (en) begin
            if (local_valid[b] && neighbor_valid[b]) begin
               nc++;
               if (m_rr_nb[b]) gn[b] = 1'b1;
               else            gl[b] = 1'b1;
               m_rr_nb[b] = ~m_rr_nb[b];
            end else begin
               gl[b] = local_valid[b];
               gn[b] = neighbor_valid[b];
            end
         end
         if (local_valid[b])
            check($sformatf("local_ready[%0d]", b), 32'(local_ready[b]), 32'(gl[b]));
         if (neighbor_valid[b])
            check($sformatf("neighbor_ready[%0d]", b), 32'(neighbor_ready[b]), 32'(gn[b]));
         if (gl[b])
            exp_q[b].push_back('{cyc + 1, local_row[b], local_column[b], local_data[b]});
         else if (gn[b])
            exp_q[b].push_back('{cyc + 1, neighbor_row[b], neighbor_column[b], neighbor_data[b]});
      end
      case (m_phase)
         M_IDLE: if (start) begin
            m_phase = M_ACTIVE;
            m_cfg   = bitwidth_in;
            m_conf  = 0;
         end
         M_ACTIVE: begin
            m_conf = (m_conf + nc > 65535) ? 65535 : m_conf + nc;
            if (tile_end) m_phase = M_DRAIN;
         end
         M_DRAIN: begin
            m_conf = (m_conf + nc > 65535) ? 65535 : m_conf + nc;
            if (local_valid == '0 && neighbor_valid == '0 && !neighbor_leftover) m_phase = M_DONE;
         end
         default: m_phase = M_IDLE;
      endcase
      @(posedge clk);
      #1;
      local_valid    = local_valid & ~gl;
      neighbor_valid = neighbor_valid & ~gn;
   endtask

   task automatic finish_tile();
      int n;
      tile_end = 1'b1;
      step();
      tile_end = 1'b0;
      n = 0;
      while (m_phase != M_DONE && n < 50) begin
         step();
         n++;
      end
      if (m_phase != M_DONE) check("drain_bound", 32'(busy), 32'd0);
      step();
   endtask

   logic [7:0] dl, dn;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      clear_stim();
      model_reset();
      repeat (2) @(posedge clk);
      #3 reset_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_we", buffer_write_enable, 32'd0);
      check("rst_conflicts", 32'(conflict_count), 32'd0);

      // Local-only write on bank 5.
      start = 1'b1;
      bitwidth_in = 2'd2;
      step();
      start = 1'b0;
      check("t1_cfg", 32'(cfg_bitwidth), 32'd2);
      check("t1_busy", 32'(busy), 32'd1);
      local_valid[5] = 1'b1;
      local_row[5] = 7'd3;
      local_column[5] = 7'd7;
      local_data[5] = 8'hA5;
      step();
      check("t1_we5", 32'(buffer_write_enable[5]), 32'd1);
      check("t1_row5", 32'(buffer_row_write[5]), 32'd3);
      check("t1_col5", 32'(buffer_column_write[5]), 32'd7);
      check("t1_data5", 32'(buffer_data_write[5]), 32'hA5);

      // Four back-to-back collisions on bank 0 alternate L,N,L,N.
      rand_req(0, 0);
      rand_req(0, 1);
      neighbor_data[0] = ~local_data[0];
      for (int i = 0; i < 4; i++) begin
         dl = local_data[0];
         dn = neighbor_data[0];
         step();
         check($sformatf("t2_alt%0d", i), 32'(buffer_data_write[0]), 32'((i % 2 == 0) ? dl : dn));
         if (i < 3) begin
            if (!local_valid[0]) begin
               rand_req(0, 0);
               local_data[0] = ~neighbor_data[0];
            end
            if (!neighbor_valid[0]) begin
               rand_req(0, 1);
               neighbor_data[0] = ~local_data[0];
            end
         end
      end
      step();
      check("t2_conflicts", 32'(conflict_count), 32'd4);

      // Drain held open by neighbor_leftover for three cycles.
      tile_end = 1'b1;
      neighbor_leftover = 1'b1;
      step();
      tile_end = 1'b0;
      repeat (3) begin
         step();
         check("t4_drain_busy", 32'(busy), 32'd1);
         check("t4_drain_done", 32'(done), 32'd0);
      end
      neighbor_leftover = 1'b0;
      step();
      check("t4_done", 32'(done), 32'd1);
      check("t4_busy_off", 32'(busy), 32'd0);
      step();
      check("t4_done_once", 32'(done), 32'd0);

      // Requests in IDLE wait; start inside ACTIVE is ignored.
      rand_req(1, 0);
      rand_req(2, 0);
      step();
      step();
      start = 1'b1;
      bitwidth_in = 2'd1;
      step();
      start = 1'b0;
      step();
      start = 1'b1;
      bitwidth_in = 2'd3;
      step();
      start = 1'b0;
      check("t5_cfg_held", 32'(cfg_bitwidth), 32'd1);

      // Every bank collides at once: locals first, neighbors next cycle.
      for (int b = 0; b < BC; b++) begin
         rand_req(b, 0);
         rand_req(b, 1);
      end
      step();
      check("t3_conflicts", 32'(conflict_count), 32'd32);
      check("t3_all_we", buffer_write_enable, 32'hFFFF_FFFF);
      step();
      check("t3_nb_all_we", buffer_write_enable, 32'hFFFF_FFFF);

      // Requests during DONE get no ready and no write.
      tile_end = 1'b1;
      step();
      tile_end = 1'b0;
      step();
      rand_req(9, 0);
      step();
      check("t6_no_we9", 32'(buffer_write_enable[9]), 32'd0);
      step();
      start = 1'b1;
      bitwidth_in = 2'd2;
      step();
      start = 1'b0;

      // Asynchronous reset in the middle of an active tile.
      rand_req(3, 0);
      rand_req(3, 1);
      rand_req(4, 1);
      step();
      step();
      #1 reset_n = 1'b0;
      clear_stim();
      model_reset();
      #1;
      check("t7_we", buffer_write_enable, 32'd0);
      check("t7_conflicts", 32'(conflict_count), 32'd0);
      check("t7_cfg", 32'(cfg_bitwidth), 32'd0);
      check("t7_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #2 reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Saturation: 32 collisions per cycle for 2200 cycles.
      start = 1'b1;
      bitwidth_in = 2'd3;
      step();
      start = 1'b0;
      for (int i = 0; i < 2200; i++) begin
         for (int b = 0; b < BC; b++) begin
            if (!local_valid[b]) rand_req(b, 0);
            if (!neighbor_valid[b]) rand_req(b, 1);
         end
         step();
      end
      check("t8_saturated", 32'(conflict_count), 32'h0000_FFFF);
      finish_tile();

      // Random tiles with random load, leftover and stray starts.
      for (int t = 0; t < 6; t++) begin
         int pl, pn;
         pl = $urandom_range(10, 90);
         pn = $urandom_range(10, 90);
         start = 1'b1;
         bitwidth_in = 2'($urandom);
         step();
         start = 1'b0;
         for (int k = 0; k < 60; k++) begin
            for (int b = 0; b < BC; b++) begin
               if (!local_valid[b] && $urandom_range(0, 99) < pl) rand_req(b, 0);
               if (!neighbor_valid[b] && $urandom_range(0, 99) < pn) rand_req(b, 1);
            end
            start = ($urandom_range(0, 9) == 0);
            bitwidth_in = 2'($urandom);
            step();
         end
         start = 1'b0;
         tile_end = 1'b1;
         step();
         tile_end = 1'b0;
         for (int j = 0; j < 100 && m_phase != M_DONE; j++) begin
            neighbor_leftover = (j < 8) ? 1'($urandom) : 1'b0;
            if (j < 8) begin
               for (int b = 0; b < BC; b++)
                  if (!local_valid[b] && $urandom_range(0, 99) < 20) rand_req(b, 0);
            end
            step();
         end
         neighbor_leftover = 1'b0;
         if (m_phase != M_DONE) check("rand_drain_bound", 32'(busy), 32'd0);
         step();
         step();
      end

      step();
      step();
      for (int b = 0; b < BC; b++)
         check($sformatf("pending_exp[%0d]", b), 32'(exp_q[b].size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
